// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command/display bundle between the button logic and the stopwatch controller
//   start_stop, reset_cnt, lap : level command inputs, rising-edge detected by the controller
//   q                          : live BCD count, digit 0 in q[3:0]
//   disp                       : frozen lap value or live count, for the display driver
//   run, ovf, tick, lap_active : status flags
//   master modport = button side, slave modport = controller side
interface bcd_stopwatch_ctrl_if #(parameter int DIGITS = 4);
    logic                  start_stop;
    logic                  reset_cnt;
    logic                  lap;
    logic [4*DIGITS-1:0]   q;
    logic [4*DIGITS-1:0]   disp;
    logic                  run;
    logic                  ovf;
    logic                  tick;
    logic                  lap_active;
    modport master(output start_stop, reset_cnt, lap, input q, disp, run, ovf, tick, lap_active);
    modport slave(input start_stop, reset_cnt, lap, output q, disp, run, ovf, tick, lap_active);
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: stopwatch FSM driving a synchronous chain of BCD decade counters
//   CLK : system clock, rising edge
//   CLR : synchronous active-high reset
//   bus : bcd_stopwatch_ctrl_if.slave (commands in; q, disp, run, ovf, tick, lap_active out)
// Optional lap freeze is built only when BCD_STOPWATCH_LAP_EN is defined; otherwise
// lap is ignored, lap_active is 0 and disp mirrors q with no storage.
module bcd_stopwatch_ctrl #(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 10,
    parameter bit STOP_AT_MAX = 1'b0
) (
    input logic CLK,
    input logic CLR,
    bcd_stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    state_t                 state;
    logic [PW-1:0]          psc;
    logic [DIGITS-1:0][3:0] d;
    logic [DIGITS-1:0]      en;
    logic [DIGITS-1:0]      nine;
    logic                   ovf, ss_q, rc_q, ss_e, rc_e, tick, all9, hold;
    // Carry chain: digit i is enabled by the tick only when every lower digit sits at 9.
    always_comb begin
        logic c;
        ss_e = bus.start_stop & ~ss_q;
        rc_e = bus.reset_cnt & ~rc_q;
        tick = state == RUN && psc == PMAX;
        c = tick;
        for (int i = 0; i < DIGITS; i++) begin
            nine[i] = d[i] == 4'd9;
            en[i]   = c;
            c       = c & nine[i];
        end
        all9 = &nine;
        hold = tick && all9 && STOP_AT_MAX;
    end
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            psc   <= '0;
            d     <= '0;
            ovf   <= 1'b0;
            ss_q  <= 1'b1;
            rc_q  <= 1'b1;
        end else begin
            ss_q <= bus.start_stop;
            rc_q <= bus.reset_cnt;
            if (rc_e) begin
                state <= IDLE;
                psc   <= '0;
                d     <= '0;
                ovf   <= 1'b0;
            end else begin
                if (state == RUN)
                    psc <= psc == PMAX ? '0 : psc + 1'b1;
                // Out-of-range digits (10..15) fall back to 0 on their next enable.
                for (int i = 0; i < DIGITS; i++)
                    if (en[i] && !hold)
                        d[i] <= d[i] >= 4'd9 ? 4'd0 : d[i] + 4'd1;
                if (tick && all9)
                    ovf <= 1'b1;
                // Freezing at max wins over a same-cycle pause request.
                if (hold)
                    state <= HALT;
                else if (ss_e) begin
                    state <= state == RUN ? PAUSE : state == HALT ? HALT : RUN;
                    if (state == IDLE)
                        psc <= '0;
                end
            end
        end
    end
    assign bus.q    = d;
    assign bus.run  = state == RUN;
    assign bus.ovf  = ovf;
    assign bus.tick = tick;
`ifdef BCD_STOPWATCH_LAP_EN
    logic                lap_q, lap_active, lap_e;
    logic [4*DIGITS-1:0] disp_r;
    assign lap_e = bus.lap & ~lap_q;
    always_ff @(posedge CLK) begin
        if (CLR) begin
            lap_q      <= 1'b1;
            lap_active <= 1'b0;
            disp_r     <= '0;
        end else begin
            lap_q <= bus.lap;
            if (rc_e)
                lap_active <= 1'b0;
            else if (lap_e && (state == RUN || state == PAUSE)) begin
                lap_active <= ~lap_active;
                if (!lap_active)
                    disp_r <= d;
            end
        end
    end
    assign bus.disp       = lap_active ? disp_r : d;
    assign bus.lap_active = lap_active;
`else
    logic unused_lap;
    assign unused_lap     = bus.lap;
    assign bus.disp       = d;
    assign bus.lap_active = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: checks a wrapping and a halting stopwatch against an integer reference model
module tb_bcd_stopwatch_ctrl;
    localparam int P = 3;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_HALT} mst_t;
    typedef struct {
        mst_t st;
        int   psc;
        int   cnt;
        bit   ovf;
        bit   lapa;
        int   lapv;
        bit   pss, prc, plp;
    } model_t;
    typedef struct {
        bit         clr, ss, rc;
        int         n;
        logic [7:0] q;
        bit         run, ovf;
        int         ticks;
    } vec_t;

    logic   CLK = 1'b0;
    logic   CLR = 1'b1;
    int     nchk = 0;
    int     nerr = 0;
    bit     armed = 1'b0;
    model_t m[2];
    vec_t   tbl[9];

    always #5 CLK = ~CLK;

    bcd_stopwatch_ctrl_if #(.DIGITS(2)) ba();
    bcd_stopwatch_ctrl_if #(.DIGITS(2)) bb();
    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(P), .STOP_AT_MAX(1'b0)) dut_a(.CLK(CLK), .CLR(CLR), .bus(ba));
    bcd_stopwatch_ctrl #(.DIGITS(2), .PRESCALE(P), .STOP_AT_MAX(1'b1)) dut_b(.CLK(CLK), .CLR(CLR), .bus(bb));

    function automatic logic [7:0] bcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Reference: the count is a plain integer 0..99, the prescaler a phase modulo P.
    function automatic model_t mstep(model_t s, bit smax, bit clr, bit ss, bit rc, bit lp);
        model_t n = s;
        bit tk;
        if (clr) begin
            n.st = M_IDLE; n.psc = 0; n.cnt = 0; n.ovf = 0; n.lapa = 0; n.lapv = 0;
            n.pss = 1; n.prc = 1; n.plp = 1;
            return n;
        end
        n.pss = ss; n.prc = rc; n.plp = lp;
        if (rc && !s.prc) begin
            n.st = M_IDLE; n.cnt = 0; n.psc = 0; n.ovf = 0; n.lapa = 0;
            return n;
        end
        tk = s.st == M_RUN && s.psc == P - 1;
        if (LAP_ON && lp && !s.plp && (s.st == M_RUN || s.st == M_PAUSE)) begin
            if (!s.lapa) n.lapv = s.cnt;
            n.lapa = !s.lapa;
        end
        if (s.st == M_RUN) n.psc = (s.psc + 1) % P;
        if (tk) begin
            if (s.cnt == 99) begin
                n.ovf = 1;
                if (smax) n.st = M_HALT;
                else n.cnt = 0;
            end else n.cnt = s.cnt + 1;
        end
        if (n.st != M_HALT && ss && !s.pss) begin
            if (s.st == M_IDLE) begin n.st = M_RUN; n.psc = 0; end
            else if (s.st == M_RUN) n.st = M_PAUSE;
            else if (s.st == M_PAUSE) n.st = M_RUN;
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_one(string tag, int k, logic [7:0] q, logic [7:0] disp,
                           logic run, logic ovf, logic tick, logic la);
        chk({tag, "_q"}, 32'(q), 32'(bcd(m[k].cnt)));
        chk({tag, "_disp"}, 32'(disp), 32'(bcd(m[k].lapa ? m[k].lapv : m[k].cnt)));
        chk({tag, "_run"}, 32'(run), 32'(m[k].st == M_RUN));
        chk({tag, "_ovf"}, 32'(ovf), 32'(m[k].ovf));
        chk({tag, "_tick"}, 32'(tick), 32'(m[k].st == M_RUN && m[k].psc == P - 1));
        chk({tag, "_lap_active"}, 32'(la), 32'(m[k].lapa));
    endtask

    task automatic cyc(bit clr, bit ss, bit rc, bit lp);
        CLR = clr;
        ba.start_stop = ss; ba.reset_cnt = rc; ba.lap = lp;
        bb.start_stop = ss; bb.reset_cnt = rc; bb.lap = lp;
        @(posedge CLK);
        m[0] = mstep(m[0], 1'b0, clr, ss, rc, lp);
        m[1] = mstep(m[1], 1'b1, clr, ss, rc, lp);
        if (clr) armed = 1'b1;
        #1;
        if (armed) begin
            cmp_one("a", 0, ba.q, ba.disp, ba.run, ba.ovf, ba.tick, ba.lap_active);
            cmp_one("b", 1, bb.q, bb.disp, bb.run, bb.ovf, bb.tick, bb.lap_active);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit ss, lp;
        int ticks;
        tbl[0] = '{1, 0, 0, 2,  8'h00, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 1,  8'h00, 0, 0, 0};
        tbl[2] = '{0, 1, 0, 1,  8'h00, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 30, 8'h10, 1, 0, 10};
        tbl[4] = '{0, 1, 0, 1,  8'h10, 0, 0, 0};
        tbl[5] = '{0, 0, 0, 20, 8'h10, 0, 0, 0};
        tbl[6] = '{0, 1, 0, 1,  8'h10, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 1,  8'h10, 1, 0, 1};
        tbl[8] = '{0, 0, 0, 1,  8'h11, 1, 0, 0};
        ba.start_stop = 0; ba.reset_cnt = 0; ba.lap = 0;
        bb.start_stop = 0; bb.reset_cnt = 0; bb.lap = 0;
        for (int v = 0; v < 9; v++) begin
            ticks = 0;
            for (int c = 0; c < tbl[v].n; c++) begin
                cyc(tbl[v].clr, tbl[v].ss, tbl[v].rc, 1'b0);
                ticks += int'(ba.tick);
            end
            chk($sformatf("vec%0d_q", v), 32'(ba.q), 32'(tbl[v].q));
            chk($sformatf("vec%0d_run", v), 32'(ba.run), 32'(tbl[v].run));
            chk($sformatf("vec%0d_ovf", v), 32'(ba.ovf), 32'(tbl[v].ovf));
            chk($sformatf("vec%0d_ticks", v), 32'(ticks), 32'(tbl[v].ticks));
        end
        // full-scale run: wrap versus freeze
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat (300) cyc(0, 0, 0, 0);
        chk("wrap_a_q", 32'(ba.q), 32'h00);
        chk("wrap_a_ovf", 32'(ba.ovf), 32'd1);
        chk("wrap_a_run", 32'(ba.run), 32'd1);
        chk("halt_b_q", 32'(bb.q), 32'h99);
        chk("halt_b_ovf", 32'(bb.ovf), 32'd1);
        chk("halt_b_run", 32'(bb.run), 32'd0);
        cyc(0, 1, 0, 0);
        chk("halt_b_start_q", 32'(bb.q), 32'h99);
        chk("halt_b_start_run", 32'(bb.run), 32'd0);
        cyc(0, 0, 0, 0);
        // reset, start and tick in one cycle at 42
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 500 && !found; i++)
            if (ba.q == 8'h42 && ba.tick) found = 1;
            else cyc(0, 0, 0, 0);
        chk("reach_42_tick", 32'(found), 32'd1);
        cyc(0, 1, 1, 0);
        chk("simul_q", 32'(ba.q), 32'h00);
        chk("simul_run", 32'(ba.run), 32'd0);
        chk("simul_ovf", 32'(ba.ovf), 32'd0);
        // start held high through reset release
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("rel_held_run_a", 32'(ba.run), 32'd0);
        chk("rel_held_run_b", 32'(bb.run), 32'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("rel_rise_run", 32'(ba.run), 32'd1);
        // lap freeze at 17, nine more ticks, release
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++)
            if (ba.q == 8'h17) found = 1;
            else cyc(0, 0, 0, 0);
        chk("reach_17", 32'(found), 32'd1);
        cyc(0, 0, 0, 1);
        chk("lap1_active", 32'(ba.lap_active), 32'(LAP_ON));
        chk("lap1_disp", 32'(ba.disp), 32'h17);
        repeat (26) cyc(0, 0, 0, 0);
        chk("lap_run_q", 32'(ba.q), 32'h26);
        chk("lap_run_disp", 32'(ba.disp), LAP_ON ? 32'h17 : 32'h26);
        chk("lap_run_active", 32'(ba.lap_active), 32'(LAP_ON));
        cyc(0, 0, 0, 1);
        chk("lap2_disp", 32'(ba.disp), 32'h26);
        chk("lap2_active", 32'(ba.lap_active), 32'd0);
        cyc(0, 0, 0, 0);
        // random commands against the model
        ss = 0;
        lp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ss = ~ss;
            if ($urandom_range(0, 9) == 0) lp = ~lp;
            cyc($urandom_range(0, 1499) == 0, ss, $urandom_range(0, 399) == 0, lp);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
